// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between core datapath and byte-addressed data memory
// Ports: clk/reset (sync, active-high); req_i/store_i/funct3_i/addr_i/wdata_i request from core;
//        busy_o/done_o/err_o/rdata_o response to core; daddr_o/dwdata_o/dwe_o/dce_o to memory;
//        drdata_i/dvalid_i/derror_i from memory.
module lsu_ctrl #(
    parameter logic [31:0] ADDR_LIMIT = 32'd128,
    parameter int          TIMEOUT    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic [31:0] daddr_o,
    output logic [31:0] dwdata_o,
    output logic [3:0]  dwe_o,
    output logic        dce_o,
    input  logic [31:0] drdata_i,
    input  logic        dvalid_i,
    input  logic        derror_i
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t        r_state;
    logic          r_store;
    logic [2:0]    r_funct3;
    logic [1:0]    r_off;
    logic [CW-1:0] r_cnt;
    logic          w_illegal;
    logic [3:0]    w_dwe;
    logic [31:0]   w_dwdata;
    logic [31:0]   w_sh;
    logic [31:0]   w_load;
    always_comb begin
        w_illegal = (store_i ? funct3_i > 3'd2 : !(funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
                  || (funct3_i[1:0] == 2'b01 && addr_i[0])
                  || (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00)
                  || addr_i >= ADDR_LIMIT;
        w_dwe = !store_i ? 4'b0000 :
                funct3_i[1:0] == 2'b00 ? 4'b0001 << addr_i[1:0] :
                funct3_i[1:0] == 2'b01 ? 4'b0011 << addr_i[1:0] : 4'b1111;
        w_dwdata = funct3_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}} :
                   funct3_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
        // bring the addressed byte/half down to bit 0 before extension
        w_sh = drdata_i >> {r_off, 3'b000};
        w_load = r_funct3 == 3'd0 ? {{24{w_sh[7]}}, w_sh[7:0]} :
                 r_funct3 == 3'd1 ? {{16{w_sh[15]}}, w_sh[15:0]} :
                 r_funct3 == 3'd4 ? {24'd0, w_sh[7:0]} :
                 r_funct3 == 3'd5 ? {16'd0, w_sh[15:0]} : w_sh;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_store  <= 1'b0;
            r_funct3 <= 3'd0;
            r_off    <= 2'd0;
            r_cnt    <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= 32'd0;
            daddr_o  <= 32'd0;
            dwdata_o <= 32'd0;
            dwe_o    <= 4'd0;
            dce_o    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done_o <= 1'b0;
                    err_o  <= 1'b0;
                    if (req_i) begin
                        r_store  <= store_i;
                        r_funct3 <= funct3_i;
                        r_off    <= addr_i[1:0];
                        busy_o   <= 1'b1;
                        if (w_illegal) begin
                            r_state <= RESP;
                            done_o  <= 1'b1;
                            err_o   <= 1'b1;
                        end else begin
                            r_state  <= ACCESS;
                            dce_o    <= 1'b1;
                            dwe_o    <= w_dwe;
                            daddr_o  <= addr_i;
                            dwdata_o <= w_dwdata;
                        end
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    // dvalid_i takes priority over a timeout expiring in the same cycle
                    if (dvalid_i || r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state <= RESP;
                        done_o  <= 1'b1;
                        err_o   <= dvalid_i ? derror_i : 1'b1;
                        dce_o   <= 1'b0;
                        dwe_o   <= 4'd0;
                        r_cnt   <= '0;
                        if (dvalid_i && !derror_i && !r_store) rdata_o <= w_load;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    done_o  <= 1'b0;
                    err_o   <= 1'b0;
                    busy_o  <= 1'b0;
                    r_cnt   <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized and directed checks of lsu_ctrl against a byte-array reference model
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        reset, req_i, store_i, dvalid_i, derror_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i, drdata_i;
    logic        busy_o, done_o, err_o, dce_o;
    logic [31:0] rdata_o, daddr_o, dwdata_o;
    logic [3:0]  dwe_o;
    int          pass_n = 0;
    int          total_n = 0;
    logic [7:0]  ram [128];
    logic [7:0]  ref_mem [128];
    logic [31:0] exp_rdata;
    int          o_cyc, o_acc;
    logic        o_err, o_ce, o_addr_ok, o_one;
    logic [3:0]  o_we;
    logic [31:0] o_wdat, o_rd;
    logic        e_legal, e_err;
    int          e_cyc;
    logic [3:0]  e_we;
    logic [31:0] e_wdat;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk(clk), .reset(reset), .req_i(req_i), .store_i(store_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .rdata_o(rdata_o), .daddr_o(daddr_o), .dwdata_o(dwdata_o), .dwe_o(dwe_o), .dce_o(dce_o),
        .drdata_i(drdata_i), .dvalid_i(dvalid_i), .derror_i(derror_i)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // lat = ACCESS cycle on which the memory answers; 0 = never answers
    task automatic xact(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input int lat, input logic derr, input logic wiggle);
        int size, base;
        logic [31:0] v;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        e_legal = (st ? f3 <= 3'd2 : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5)) && (a % 32'(size) == 0) && a < 32'd128;
        e_err = !e_legal || derr || lat == 0;
        e_cyc = !e_legal ? 1 : (lat == 0 ? 9 : lat + 1);
        e_we = 4'd0;
        e_wdat = 32'd0;
        for (int j = 0; j < 4; j++) e_wdat[8*j +: 8] = wd[8*(j % size) +: 8];
        if (st && e_legal) for (int i = 0; i < size; i++) e_we[int'(a[1:0]) + i] = 1'b1;
        if (!e_err) begin
            if (st) begin
                for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
                for (int i = size; i < 4; i++) v[8*i +: 8] = (!f3[2] && v[8*size-1]) ? 8'hFF : 8'h00;
                exp_rdata = v;
            end
        end
        @(negedge clk);
        req_i = 1'b1; store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd;
        dvalid_i = 1'b0; derror_i = 1'b0;
        o_cyc = 0; o_acc = 0; o_ce = 1'b0; o_addr_ok = 1'b1; o_we = 4'd0; o_wdat = 32'd0;
        while (o_cyc < 20) begin
            @(posedge clk); #1;
            o_cyc++;
            dvalid_i = 1'b0;
            derror_i = 1'b0;
            if (done_o) break;
            if (dce_o) begin
                o_ce = 1'b1;
                o_acc++;
                o_we = dwe_o;
                o_wdat = dwdata_o;
                if (daddr_o !== a) o_addr_ok = 1'b0;
                base = int'({daddr_o[6:2], 2'b00});
                drdata_i = {ram[base+3], ram[base+2], ram[base+1], ram[base]};
                if (o_acc == lat) begin
                    dvalid_i = 1'b1;
                    derror_i = derr;
                    if (!derr) for (int j = 0; j < 4; j++) if (dwe_o[j]) ram[base+j] = dwdata_o[8*j +: 8];
                end
            end
            if (wiggle) begin
                req_i = ~req_i;
                store_i = ~store_i;
                addr_i = $urandom_range(0, 127);
            end
        end
        o_err = err_o;
        o_rd = rdata_o;
        req_i = 1'b0; dvalid_i = 1'b0; derror_i = 1'b0;
        @(posedge clk); #1;
        o_one = !done_o && !busy_o;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_i = 1'b0; store_i = 1'b0; funct3_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0;
        drdata_i = 32'd0; dvalid_i = 1'b0; derror_i = 1'b0;
        for (int i = 0; i < 128; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        exp_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        total_n++; if ({busy_o, done_o, err_o, dce_o} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {busy_o, done_o, err_o, dce_o}); else pass_n++;
        total_n++; if (dwe_o !== 4'd0) $display("FAIL reset_dwe: got %h want 0", dwe_o); else pass_n++;
        total_n++; if (daddr_o !== 32'd0 || dwdata_o !== 32'd0) $display("FAIL reset_dbus: got %h/%h want 0/0", daddr_o, dwdata_o); else pass_n++;
        total_n++; if (rdata_o !== 32'd0) $display("FAIL reset_rdata: got %h want 0", rdata_o); else pass_n++;
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 2, 1'b0, 1'b0);
        total_n++; if (o_we !== 4'b1111) $display("FAIL sw_dwe: got %b want 1111", o_we); else pass_n++;
        total_n++; if (o_err !== 1'b0 || o_cyc != 3) $display("FAIL sw_done: err %b cyc %0d want 0 3", o_err, o_cyc); else pass_n++;
        xact(1'b0, 3'd2, 32'h10, 32'd0, 1, 1'b0, 1'b0);
        total_n++; if (o_rd !== 32'hDEADBEEF) $display("FAIL lw_10: got %h want DEADBEEF", o_rd); else pass_n++;
        xact(1'b1, 3'd0, 32'h11, 32'h000000A5, 3, 1'b0, 1'b0);
        total_n++; if (o_we !== 4'b0010) $display("FAIL sb_dwe: got %b want 0010", o_we); else pass_n++;
        total_n++; if (o_wdat !== 32'hA5A5A5A5) $display("FAIL sb_dwdata: got %h want A5A5A5A5", o_wdat); else pass_n++;
        xact(1'b0, 3'd2, 32'h10, 32'd0, 1, 1'b0, 1'b0);
        total_n++; if (o_rd !== 32'hDEADA5EF) $display("FAIL lw_after_sb: got %h want DEADA5EF", o_rd); else pass_n++;
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] as  [4] = '{32'h11, 32'h11, 32'h12, 32'h12};
        logic [31:0] ws  [4] = '{32'hFFFFFFA5, 32'h000000A5, 32'hFFFFDEAD, 32'h0000DEAD};
        for (int i = 0; i < 4; i++) begin
            xact(1'b0, f3s[i], as[i], 32'd0, 1 + i, 1'b0, 1'b0);
            total_n++; if (o_rd !== ws[i] || o_err !== 1'b0) $display("FAIL load_ext%0d: got %h err %b want %h err 0", i, o_rd, o_err, ws[i]); else pass_n++;
        end
    endtask

    task automatic test_illegal();
        logic        sts [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3s [4] = '{3'd2, 3'd1, 3'd2, 3'd3};
        logic [31:0] as  [4] = '{32'h12, 32'h13, 32'h80, 32'h10};
        for (int i = 0; i < 4; i++) begin
            xact(sts[i], f3s[i], as[i], 32'h12345678, 1, 1'b0, 1'b0);
            total_n++; if (o_cyc != 1 || o_err !== 1'b1) $display("FAIL illegal%0d: cyc %0d err %b want 1 1", i, o_cyc, o_err); else pass_n++;
            total_n++; if (o_ce !== 1'b0) $display("FAIL illegal%0d_dce: got %b want 0", i, o_ce); else pass_n++;
            total_n++; if (o_rd !== 32'h0000DEAD) $display("FAIL illegal%0d_rdata: got %h want 0000DEAD", i, o_rd); else pass_n++;
        end
    endtask

    task automatic test_timeout();
        xact(1'b0, 3'd2, 32'h20, 32'd0, 0, 1'b0, 1'b1);
        total_n++; if (o_cyc != 9 || o_acc != 8 || o_err !== 1'b1) $display("FAIL timeout: cyc %0d acc %0d err %b want 9 8 1", o_cyc, o_acc, o_err); else pass_n++;
        total_n++; if (o_addr_ok !== 1'b1 || o_one !== 1'b1) $display("FAIL busy_ignore: addr_ok %b idle_after %b want 1 1", o_addr_ok, o_one); else pass_n++;
        total_n++; if (o_rd !== 32'h0000DEAD) $display("FAIL timeout_rdata: got %h want 0000DEAD", o_rd); else pass_n++;
        xact(1'b0, 3'd2, 32'h24, 32'd0, 8, 1'b0, 1'b0);
        total_n++; if (o_cyc != 9 || o_err !== 1'b0 || o_rd !== exp_rdata) $display("FAIL valid_at_timeout: cyc %0d err %b rd %h want 9 0 %h", o_cyc, o_err, o_rd, exp_rdata); else pass_n++;
        xact(1'b1, 3'd2, 32'd124, 32'hCAFEF00D, 1, 1'b0, 1'b0);
        xact(1'b0, 3'd2, 32'd124, 32'd0, 2, 1'b0, 1'b0);
        total_n++; if (o_err !== 1'b0 || o_rd !== 32'hCAFEF00D) $display("FAIL lw_limit_m4: err %b rd %h want 0 CAFEF00D", o_err, o_rd); else pass_n++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_i = 1'b1; store_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h20; wdata_i = 32'h0BADF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total_n++; if (dce_o !== 1'b1 || busy_o !== 1'b1) $display("FAIL mid_access: dce %b busy %b want 1 1", dce_o, busy_o); else pass_n++;
        reset = 1'b1; req_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        total_n++; if ({busy_o, dce_o, done_o, dwe_o} !== 7'd0) $display("FAIL reset_mid: busy %b dce %b done %b dwe %b want all 0", busy_o, dce_o, done_o, dwe_o); else pass_n++;
        exp_rdata = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total_n++; if (done_o !== 1'b0) $display("FAIL reset_no_done%0d: got %b want 0", i, done_o); else pass_n++;
        end
        xact(1'b0, 3'd2, 32'h20, 32'd0, 2, 1'b0, 1'b0);
        total_n++; if (o_err !== 1'b0 || o_cyc != 3 || o_rd !== exp_rdata) $display("FAIL lw_after_reset: err %b cyc %0d rd %h want 0 3 %h", o_err, o_cyc, o_rd, exp_rdata); else pass_n++;
    endtask

    task automatic test_random();
        logic        st, derr;
        logic [2:0]  f3;
        logic [31:0] a;
        int          lat;
        logic [2:0]  legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int n = 0; n < 60; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, st ? 2 : 4)] : 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 5) == 0) ? $urandom_range(120, 140) : $urandom_range(0, 31) * 4 + (($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0);
            lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
            derr = ($urandom_range(0, 7) == 0);
            xact(st, f3, a, $urandom, lat, derr, 1'b0);
            total_n++; if (o_cyc != e_cyc || o_err !== e_err) $display("FAIL rnd%0d_resp: cyc %0d err %b want %0d %b", n, o_cyc, o_err, e_cyc, e_err); else pass_n++;
            total_n++; if (o_ce !== e_legal || o_addr_ok !== 1'b1) $display("FAIL rnd%0d_dce: dce %b addr_ok %b want %b 1", n, o_ce, o_addr_ok, e_legal); else pass_n++;
            total_n++; if (o_rd !== exp_rdata || o_one !== 1'b1) $display("FAIL rnd%0d_rdata: rd %h one %b want %h 1", n, o_rd, o_one, exp_rdata); else pass_n++;
            if (e_legal) begin
                total_n++; if (o_we !== e_we) $display("FAIL rnd%0d_dwe: got %b want %b", n, o_we, e_we); else pass_n++;
                if (st) begin
                    total_n++; if (o_wdat !== e_wdat) $display("FAIL rnd%0d_dwdata: got %h want %h", n, o_wdat, e_wdat); else pass_n++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_load_ext();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
